// File: rtl/alu_share_sched.sv
// alu_share_sched: round-robin scheduler sharing one add/sub/and/or ALU among N_REQ requesters
// Ports: clk, rst (async, active-high)
//        req_valid/req_ready/req_op/req_a/req_b : per-requester request handshake, slice i per requester
//        rsp_valid/rsp_ready/rsp_data/rsp_id/rsp_carry/rsp_zero : tagged result handshake
//        busy : high whenever a transaction is in flight
module alu_share_sched #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int ID_W  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [2*N_REQ-1:0]     req_op,
    input  logic [WIDTH*N_REQ-1:0] req_a,
    input  logic [WIDTH*N_REQ-1:0] req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [WIDTH-1:0]       rsp_data,
    output logic [ID_W-1:0]        rsp_id,
    output logic                   rsp_carry,
    output logic                   rsp_zero,
    output logic                   busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t           r_state, w_next;
    logic [ID_W-1:0]  r_ptr, r_id, w_win;
    logic             w_found;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_a, r_b;
    logic [WIDTH:0]   w_res;
    // scan ptr+1, ptr+2, ... so the last winner has lowest priority
    always_comb begin
        w_found = 1'b0;
        w_win   = r_ptr;
        for (int k = 1; k <= N_REQ; k++)
            if (!w_found && req_valid[(int'(r_ptr) + k) % N_REQ]) begin
                w_found = 1'b1;
                w_win   = ID_W'((int'(r_ptr) + k) % N_REQ);
            end
    end
    always_comb w_next = r_state == IDLE ? (w_found ? EXEC : IDLE) :
                         r_state == EXEC ? RESP : (rsp_ready ? IDLE : RESP);
    // add/sub at WIDTH+1 bits: the top bit is carry for add, borrow for sub
    always_comb w_res = r_op == 2'b00 ? {1'b0, r_a} + {1'b0, r_b} :
                        r_op == 2'b01 ? {1'b0, r_a} - {1'b0, r_b} :
                        r_op == 2'b10 ? {1'b0, r_a & r_b} : {1'b0, r_a | r_b};
    assign req_ready = (r_state == IDLE && w_found && !rst) ? N_REQ'(1) << w_win : '0;
    assign rsp_valid = r_state == RESP;
    assign busy      = r_state != IDLE;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_ptr     <= ID_W'(N_REQ - 1);
            r_id      <= '0;
            r_op      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            rsp_data  <= '0;
            rsp_id    <= '0;
            rsp_carry <= 1'b0;
            rsp_zero  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_found) begin
                r_ptr <= w_win;
                r_id  <= w_win;
                r_op  <= req_op[2*w_win +: 2];
                r_a   <= req_a[WIDTH*w_win +: WIDTH];
                r_b   <= req_b[WIDTH*w_win +: WIDTH];
            end
            if (r_state == EXEC) begin
                rsp_data  <= w_res[WIDTH-1:0];
                rsp_carry <= w_res[WIDTH];
                rsp_zero  <= w_res[WIDTH-1:0] == '0;
                rsp_id    <= r_id;
            end
        end
    end
endmodule

// File: tb/tb_alu_share_sched.sv
// tb_alu_share_sched: transaction-level model check of alu_share_sched with directed and random traffic
module tb_alu_share_sched;
    localparam int N = 4;
    localparam int W = 8;
    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [2*N-1:0] req_op = '0;
    logic [W*N-1:0] req_a = '0;
    logic [W*N-1:0] req_b = '0;
    logic           rsp_valid;
    logic           rsp_ready = 1'b1;
    logic [W-1:0]   rsp_data;
    logic [1:0]     rsp_id;
    logic           rsp_carry, rsp_zero, busy;
    int total = 0;
    int bad = 0;
    bit m_inflight = 0;
    int m_age, m_ptr = N - 1, cyc = 0;
    int e_data, e_id, e_carry, e_zero;
    int g_log[$], g_cyc[$], r_data[$], r_id[$];
    logic [N-1:0] last_ready = '0;

    alu_share_sched #(.N_REQ(N), .WIDTH(W), .ID_W(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic calc(input int op, input int a, input int b);
        int s;
        s = op == 0 ? a + b : op == 1 ? a - b : op == 2 ? (a & b) : (a | b);
        e_carry = op == 0 ? int'(s > 255) : op == 1 ? int'(a < b) : 0;
        e_data  = s & ((1 << W) - 1);
        e_zero  = int'(e_data == 0);
    endtask

    // check this cycle's outputs, then advance the model across the coming edge
    task automatic model();
        int w = -1;
        logic [N-1:0] er = '0;
        if (rst) return;
        cyc++;
        for (int k = 1; k <= N; k++) begin
            int j = (m_ptr + k) % N;
            if (w < 0 && req_valid[j]) w = j;
        end
        if (!m_inflight && w >= 0) er[w] = 1'b1;
        chk("req_ready", req_ready, er);
        chk("busy", busy, m_inflight);
        chk("rsp_valid", rsp_valid, m_inflight && m_age >= 1);
        if (m_inflight && m_age >= 1) begin
            chk("rsp_data", rsp_data, e_data);
            chk("rsp_id", rsp_id, e_id);
            chk("rsp_carry", rsp_carry, e_carry);
            chk("rsp_zero", rsp_zero, e_zero);
        end
        last_ready = req_ready;
        if (rsp_valid && rsp_ready) begin
            r_data.push_back(int'(rsp_data));
            r_id.push_back(int'(rsp_id));
        end
        if (!m_inflight) begin
            if (w >= 0) begin
                m_inflight = 1;
                m_age = 0;
                m_ptr = w;
                e_id = w;
                calc(int'(req_op[2*w +: 2]), int'(req_a[W*w +: W]), int'(req_b[W*w +: W]));
                g_log.push_back(w);
                g_cyc.push_back(cyc);
            end
        end else if (m_age >= 1 && rsp_ready) m_inflight = 0;
        else m_age = 1;
    endtask

    task automatic tick();
        @(negedge clk);
        model();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input int op, input int a, input int b);
        req_op[2*i +: 2] = 2'(op);
        req_a[W*i +: W]  = W'(a);
        req_b[W*i +: W]  = W'(b);
    endtask

    task automatic wait_grant(input int i);
        int t = 0;
        do begin tick(); t++; end while (!last_ready[i] && t < 20);
        chk("grant_seen", last_ready[i], 1);
    endtask

    task automatic one(input int i, input int op, input int a, input int b,
                       input int xd, input int xc, input int xz);
        int n0, t;
        req_valid = '0;
        rsp_ready = 1'b1;
        set_req(i, op, a, b);
        req_valid[i] = 1'b1;
        wait_grant(i);
        chk("grant_onehot", last_ready, 1 << i);
        req_valid[i] = 1'b0;
        n0 = r_data.size();
        t = 0;
        do begin tick(); t++; end while (r_data.size() == n0 && t < 10);
        chk("latency", t, 2);
        if (r_data.size() > n0) begin
            chk("lit_data", r_data[n0], xd);
            chk("lit_id", r_id[n0], i);
            chk("lit_carry", rsp_carry, xc);
            chk("lit_zero", rsp_zero, xz);
        end else chk("rsp_timeout", 0, 1);
    endtask

    task automatic drain();
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (4) tick();
    endtask

    initial begin
        int n0, ng;
        int order[6] = '{0, 1, 2, 3, 0, 1};
        req_valid = '1;
        #1 rst = 1'b1;
        #2;
        chk("rst_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_data", rsp_data, 0);
        chk("rst_id", rsp_id, 0);
        chk("rst_carry", rsp_carry, 0);
        chk("rst_zero", rsp_zero, 0);
        chk("rst_ready", req_ready, 0);
        req_valid = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        one(0, 0, 'h0F, 'h01, 'h10, 0, 0);
        one(2, 0, 'hFF, 'h01, 'h00, 1, 1);
        one(1, 1, 'h03, 'h05, 'hFE, 1, 0);
        one(1, 2, 'hF0, 'h3C, 'h30, 0, 0);
        one(1, 3, 'hF0, 'h3C, 'hFC, 0, 0);
        drain();
        // back-pressure: hold the result while others wait
        set_req(0, 0, 1, 2);
        req_valid = 4'b0001;
        rsp_ready = 1'b0;
        wait_grant(0);
        for (int i = 1; i < N; i++) set_req(i, i, 'h55, 'h0A);
        req_valid = 4'b1110;
        n0 = r_data.size();
        repeat (12) tick();
        chk("hold_valid", rsp_valid, 1);
        chk("hold_data", rsp_data, 3);
        chk("hold_id", rsp_id, 0);
        chk("hold_ready", req_ready, 0);
        chk("hold_none", r_data.size(), n0);
        rsp_ready = 1'b1;
        tick();
        chk("release_rsp", r_data.size(), n0 + 1);
        chk("release_idle", busy, 0);
        req_valid = '0;
        drain();
        // random traffic
        for (int c = 0; c < 400; c++) begin
            rsp_ready = $urandom_range(3) != 0;
            tick();
            for (int i = 0; i < N; i++) begin
                if (last_ready[i] || !req_valid[i]) begin
                    int a = $urandom_range(255);
                    set_req(i, $urandom_range(3), a, $urandom_range(3) == 0 ? a : $urandom_range(255));
                end
                if (last_ready[i]) req_valid[i] = 1'($urandom_range(1));
                else if (!req_valid[i]) req_valid[i] = $urandom_range(2) == 0;
                else if ($urandom_range(15) == 0) req_valid[i] = 1'b0;
            end
        end
        drain();
        // async reset in the middle of requester 3's transaction
        set_req(3, 0, 7, 9);
        req_valid = 4'b1000;
        wait_grant(3);
        n0 = r_id.size();
        req_valid = '1;
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_valid", rsp_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", req_ready, 0);
        #1 rst = 1'b0;
        m_inflight = 0;
        m_ptr = N - 1;
        ng = g_log.size();
        for (int t = 0; t < 40 && g_log.size() < ng + 6; t++) tick();
        if (g_log.size() >= ng + 6) begin
            for (int k = 0; k < 6; k++) chk("rr_order", g_log[ng+k], order[k]);
            for (int k = 1; k < 6; k++) chk("rr_spacing", g_cyc[ng+k] - g_cyc[ng+k-1], 3);
        end else chk("rr_timeout", 0, 1);
        if (r_id.size() > n0) chk("no_rsp_after_rst", r_id[n0], 0);
        else chk("post_rst_rsp_timeout", 0, 1);
        drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
